pc_seq_unit: RTL and testbench

- Parametrised program-counter sequencer for the processor fetch stage. Successor to the fixed 10-bit PC with a hard-wired branch/jump LUT.
- Adds configurable PC width, a run-time loadable absolute-target LUT and signed-offset LUT, a call/return stack, stall, and a sticky halt/fault state.
- Drives the instruction-memory address directly.

---
 rtl/pc_seq_unit.sv | 125 ++++++++++++
 tb/tb_pc_seq_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// Fetch-stage program-counter sequencer: increment, LUT branch/jump, call/return stack,
// stall and a sticky HALT entered on request or on a stack fault.
module pc_seq_unit #(
  parameter int PC_W      = 10,
  parameter int SEL_W     = 2,
  parameter int STK_DEPTH = 4,
  localparam int CNT_W    = $clog2(STK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             init,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [SEL_W-1:0] sel,
  input  logic             lut_we,
  input  logic             lut_wtab,
  input  logic [SEL_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]  lut_wdata,
  output logic [PC_W-1:0]  PC,
  output logic             halted,
  output logic             stk_ovf,
  output logic             stk_unf,
  output logic [CNT_W-1:0] stk_cnt
);

  localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam int LUT_N = 2 ** SEL_W;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]      state;
  logic [PC_W-1:0] tgt_lut [LUT_N];
  logic [PC_W-1:0] off_lut [LUT_N];
  logic [PC_W-1:0] stack   [2**IDX_W];

  logic [PC_W-1:0]  pc_nxt;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic             push;
  logic             set_ovf;
  logic             set_unf;
  logic             go_halt;

  assign pc_inc   = PC + PC_W'(1);
  assign top_idx  = IDX_W'(stk_cnt - CNT_W'(1));
  assign push_idx = IDX_W'(stk_cnt);
  assign halted   = (state == S_HALT);

  // One request acts per cycle, highest priority first; HALT freezes everything but LUT writes.
  always_comb begin
    pc_nxt  = PC;
    cnt_nxt = stk_cnt;
    push    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    go_halt = 1'b0;
    if (state == S_RUN) begin
      if (halt_req) begin
        go_halt = 1'b1;
      end else if (stall) begin
        pc_nxt = PC;
      end else if (ret_en) begin
        if (stk_cnt != '0) begin
          pc_nxt  = stack[top_idx];
          cnt_nxt = stk_cnt - CNT_W'(1);
        end else begin
          set_unf = 1'b1;
          go_halt = 1'b1;
        end
      end else if (call_en) begin
        if (stk_cnt != CNT_W'(STK_DEPTH)) begin
          push    = 1'b1;
          pc_nxt  = tgt_lut[sel];
          cnt_nxt = stk_cnt + CNT_W'(1);
        end else begin
          set_ovf = 1'b1;
          go_halt = 1'b1;
        end
      end else if (branch_en) begin
        pc_nxt = tgt_lut[sel];
      end else if (jump_en) begin
        // Two's-complement offset: plain modular add gives the signed result.
        pc_nxt = PC + off_lut[sel];
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      PC      <= '0;
      state   <= S_RUN;
      stk_cnt <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      for (int i = 0; i < LUT_N; i++) begin
        tgt_lut[i] <= '0;
        off_lut[i] <= PC_W'(1);
      end
    end else begin
      PC      <= pc_nxt;
      stk_cnt <= cnt_nxt;
      if (set_ovf) stk_ovf <= 1'b1;
      if (set_unf) stk_unf <= 1'b1;
      if (go_halt) state <= S_HALT;
      if (lut_we) begin
        if (lut_wtab) off_lut[lut_waddr] <= lut_wdata;
        else          tgt_lut[lut_waddr] <= lut_wdata;
      end
    end
  end

  // Stack storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed and randomized checks of pc_seq_unit against a queue/array-based reference model.
module tb_pc_seq_unit;
  localparam int PC_W = 10, SEL_W = 2, DEPTH = 4, N = 1024;

  logic clk = 1'b0;
  logic init = 1'b1;
  logic stall = 0, halt_req = 0, jump_en = 0, branch_en = 0, call_en = 0, ret_en = 0;
  logic [SEL_W-1:0] sel = '0;
  logic lut_we = 0, lut_wtab = 0;
  logic [SEL_W-1:0] lut_waddr = '0;
  logic [PC_W-1:0] lut_wdata = '0;
  logic [PC_W-1:0] pc;
  logic halted, stk_ovf, stk_unf;
  logic [2:0] stk_cnt;

  int vectors = 0;
  int miscompares = 0;

  int m_pc, m_halted, m_ovf, m_unf;
  int m_tgt[4];
  int m_off[4];
  int m_stk[$];

  pc_seq_unit #(.PC_W(PC_W), .SEL_W(SEL_W), .STK_DEPTH(DEPTH)) dut (
    .clk(clk), .init(init), .stall(stall), .halt_req(halt_req), .jump_en(jump_en),
    .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en), .sel(sel),
    .lut_we(lut_we), .lut_wtab(lut_wtab), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .PC(pc), .halted(halted), .stk_ovf(stk_ovf), .stk_unf(stk_unf), .stk_cnt(stk_cnt)
  );

  always #5 clk = ~clk;

  task automatic clr_inputs();
    stall = 0; halt_req = 0; jump_en = 0; branch_en = 0; call_en = 0; ret_en = 0;
    sel = '0; lut_we = 0; lut_wtab = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
    for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_off[i] = 1; end
  endtask

  // Advance one clock: the model consumes the inputs sampled at this edge.
  task automatic tick();
    int off;
    if (m_halted == 0) begin
      if (halt_req) m_halted = 1;
      else if (stall) m_pc = m_pc;
      else if (ret_en) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_unf = 1; m_halted = 1; end
      end else if (call_en) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back((m_pc + 1) % N);
          m_pc = m_tgt[sel];
        end else begin m_ovf = 1; m_halted = 1; end
      end else if (branch_en) m_pc = m_tgt[sel];
      else if (jump_en) begin
        off  = (m_off[sel] >= N / 2) ? m_off[sel] - N : m_off[sel];
        m_pc = ((m_pc + off) % N + N) % N;
      end else m_pc = (m_pc + 1) % N;
    end
    if (lut_we) begin
      if (lut_wtab) m_off[lut_waddr] = int'(lut_wdata);
      else          m_tgt[lut_waddr] = int'(lut_wdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    clr_inputs();
    init = 1;
    model_reset();
    @(posedge clk);
    #1;
    init = 0;
  endtask

  task automatic adv_to(input int target);
    for (int i = 0; i < 2 * N && m_pc != target; i++) tick();
  endtask

  task automatic wr_lut(input logic tab, input int addr, input int data);
    lut_we = 1; lut_wtab = tab; lut_waddr = SEL_W'(addr); lut_wdata = PC_W'(data);
    tick();
    lut_we = 0;
  endtask

  task automatic test_reset();
    do_init();
    vectors++;
    if (pc !== 10'd0 || halted !== 1'b0 || stk_ovf !== 1'b0 || stk_unf !== 1'b0 || stk_cnt !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state: pc=%0d halted=%b ovf=%b unf=%b cnt=%0d, want all zero",
               pc, halted, stk_ovf, stk_unf, stk_cnt);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    do_init();
    for (int i = 1; i <= N + 1; i++) begin
      tick();
      vectors++;
      if (pc !== 10'(i % N)) begin
        miscompares++;
        if (bad++ < 5) $display("FAIL wrap_count: step %0d pc=%0d want %0d", i, pc, i % N);
      end
    end
    do_init();
    adv_to(37);
    vectors++;
    if (pc !== 10'd37) begin miscompares++; $display("FAIL pre_init_pc: pc=%0d want 37", pc); end
    init = 1;
    #2;
    vectors++;
    if (pc !== 10'd0) begin miscompares++; $display("FAIL async_init: pc=%0d want 0", pc); end
    #2;
    init = 0;
    model_reset();
    tick();
    vectors++;
    if (pc !== 10'd1) begin miscompares++; $display("FAIL first_inc: pc=%0d want 1", pc); end
  endtask

  task automatic test_lut();
    do_init();
    adv_to(5);
    jump_en = 1; sel = 2; tick(); jump_en = 0;
    vectors++;
    if (pc !== 10'd6) begin miscompares++; $display("FAIL default_jump: pc=%0d want 6", pc); end
    wr_lut(1'b1, 2, 10'h3FB);
    adv_to(12);
    jump_en = 1; sel = 2; tick(); jump_en = 0;
    vectors++;
    if (pc !== 10'd7) begin miscompares++; $display("FAIL neg_jump: pc=%0d want 7", pc); end
    wr_lut(1'b0, 1, 200);
    branch_en = 1; sel = 1; tick(); branch_en = 0;
    vectors++;
    if (pc !== 10'd200) begin miscompares++; $display("FAIL branch: pc=%0d want 200", pc); end
    lut_we = 1; lut_wtab = 0; lut_waddr = 3; lut_wdata = 50;
    branch_en = 1; sel = 3; tick(); lut_we = 0;
    vectors++;
    if (pc !== 10'd0) begin miscompares++; $display("FAIL same_cycle_old: pc=%0d want 0", pc); end
    tick(); branch_en = 0;
    vectors++;
    if (pc !== 10'd50) begin miscompares++; $display("FAIL same_cycle_new: pc=%0d want 50", pc); end
    // Wrap of a negative offset below zero.
    jump_en = 1; sel = 2; tick(); jump_en = 0;
    adv_to(2);
    jump_en = 1; sel = 2; tick(); jump_en = 0;
    vectors++;
    if (pc !== 10'd1021) begin miscompares++; $display("FAIL neg_wrap: pc=%0d want 1021", pc); end
  endtask

  task automatic test_call_ret();
    do_init();
    wr_lut(1'b0, 0, 100);
    wr_lut(1'b0, 1, 300);
    adv_to(10);
    call_en = 1; sel = 0; tick(); call_en = 0;
    vectors++;
    if (pc !== 10'd100 || stk_cnt !== 3'd1) begin
      miscompares++; $display("FAIL call1: pc=%0d cnt=%0d want 100/1", pc, stk_cnt);
    end
    adv_to(104);
    call_en = 1; sel = 1; tick(); call_en = 0;
    vectors++;
    if (pc !== 10'd300 || stk_cnt !== 3'd2) begin
      miscompares++; $display("FAIL call2: pc=%0d cnt=%0d want 300/2", pc, stk_cnt);
    end
    ret_en = 1; tick();
    vectors++;
    if (pc !== 10'd105) begin miscompares++; $display("FAIL ret1: pc=%0d want 105", pc); end
    tick(); ret_en = 0;
    vectors++;
    if (pc !== 10'd11 || stk_cnt !== 3'd0) begin
      miscompares++; $display("FAIL ret2: pc=%0d cnt=%0d want 11/0", pc, stk_cnt);
    end
  endtask

  task automatic test_overflow();
    do_init();
    wr_lut(1'b0, 0, 40);
    call_en = 1; sel = 0;
    for (int i = 0; i < DEPTH; i++) tick();
    vectors++;
    if (stk_cnt !== 3'd4 || halted !== 1'b0) begin
      miscompares++; $display("FAIL stack_full: cnt=%0d halted=%b want 4/0", stk_cnt, halted);
    end
    tick(); call_en = 0;
    vectors++;
    if (pc !== 10'd40 || stk_ovf !== 1'b1 || halted !== 1'b1 || stk_cnt !== 3'd4) begin
      miscompares++;
      $display("FAIL overflow: pc=%0d ovf=%b halted=%b cnt=%0d want 40/1/1/4", pc, stk_ovf, halted, stk_cnt);
    end
    ret_en = 1; tick(); ret_en = 0;
    branch_en = 1; tick(); branch_en = 0;
    tick();
    vectors++;
    if (pc !== 10'd40 || stk_cnt !== 3'd4 || halted !== 1'b1 || stk_unf !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_frozen: pc=%0d cnt=%0d halted=%b unf=%b want 40/4/1/0", pc, stk_cnt, halted, stk_unf);
    end
  endtask

  task automatic test_underflow();
    do_init();
    ret_en = 1; tick(); ret_en = 0;
    tick();
    vectors++;
    if (pc !== 10'd0 || stk_unf !== 1'b1 || halted !== 1'b1 || stk_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow: pc=%0d unf=%b halted=%b ovf=%b want 0/1/1/0", pc, stk_unf, halted, stk_ovf);
    end
  endtask

  task automatic test_priority();
    do_init();
    adv_to(7);
    call_en = 1; sel = 0; tick(); call_en = 0;
    adv_to(20);
    stall = 1; branch_en = 1; jump_en = 1; sel = 0; tick();
    stall = 0; branch_en = 0; jump_en = 0;
    vectors++;
    if (pc !== 10'd20 || stk_cnt !== 3'd1) begin
      miscompares++; $display("FAIL prio_stall: pc=%0d cnt=%0d want 20/1", pc, stk_cnt);
    end
    ret_en = 1; call_en = 1; tick(); ret_en = 0; call_en = 0;
    vectors++;
    if (pc !== 10'd8 || stk_cnt !== 3'd0) begin
      miscompares++; $display("FAIL prio_ret: pc=%0d cnt=%0d want 8/0", pc, stk_cnt);
    end
    wr_lut(1'b0, 2, 50);
    branch_en = 1; jump_en = 1; sel = 2; tick(); branch_en = 0; jump_en = 0;
    vectors++;
    if (pc !== 10'd50) begin miscompares++; $display("FAIL prio_branch: pc=%0d want 50", pc); end
    call_en = 1; sel = 2; tick(); call_en = 0;
    halt_req = 1; ret_en = 1; tick(); halt_req = 0; ret_en = 0;
    vectors++;
    if (halted !== 1'b1 || stk_cnt !== 3'd1 || pc !== 10'd50) begin
      miscompares++; $display("FAIL prio_halt: halted=%b cnt=%0d pc=%0d want 1/1/50", halted, stk_cnt, pc);
    end
  endtask

  task automatic test_stall_lut();
    do_init();
    adv_to(3);
    stall = 1; lut_we = 1; lut_wtab = 0; lut_waddr = 2; lut_wdata = 77;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pc !== 10'd3) begin miscompares++; $display("FAIL stall_hold: cycle %0d pc=%0d want 3", i, pc); end
    end
    stall = 0; lut_we = 0;
    branch_en = 1; sel = 2; tick(); branch_en = 0;
    vectors++;
    if (pc !== 10'd77) begin miscompares++; $display("FAIL stall_lut_branch: pc=%0d want 77", pc); end
  endtask

  task automatic test_random();
    int halt_age = 0;
    int bad = 0;
    do_init();
    for (int c = 0; c < 3000; c++) begin
      halt_req  = ($urandom_range(0, 199) == 0);
      stall     = ($urandom_range(0, 9) == 0);
      ret_en    = ($urandom_range(0, 4) == 0);
      call_en   = ($urandom_range(0, 4) == 0);
      branch_en = ($urandom_range(0, 4) == 0);
      jump_en   = ($urandom_range(0, 3) == 0);
      sel       = SEL_W'($urandom_range(0, 3));
      lut_we    = ($urandom_range(0, 3) == 0);
      lut_wtab  = 1'($urandom_range(0, 1));
      lut_waddr = SEL_W'($urandom_range(0, 3));
      lut_wdata = PC_W'($urandom_range(0, N - 1));
      tick();
      vectors++;
      if (pc !== 10'(m_pc) || halted !== 1'(m_halted) || stk_ovf !== 1'(m_ovf) ||
          stk_unf !== 1'(m_unf) || stk_cnt !== 3'(m_stk.size())) begin
        miscompares++;
        if (bad++ < 8)
          $display("FAIL random c=%0d: pc=%0d h=%b o=%b u=%b cnt=%0d want %0d/%0d/%0d/%0d/%0d",
                   c, pc, halted, stk_ovf, stk_unf, stk_cnt, m_pc, m_halted, m_ovf, m_unf, m_stk.size());
      end
      halt_age = m_halted ? halt_age + 1 : 0;
      if (halt_age > 6) begin do_init(); halt_age = 0; end
    end
    clr_inputs();
  endtask

  initial begin
    clr_inputs();
    model_reset();
    #12;
    test_reset();
    test_wrap();
    test_lut();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_priority();
    test_stall_lut();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
